// File: rtl/store_pkg.sv
// Shared encodings and lane helpers for the store byte-merge path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package store_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   // Byte lanes touched by a store of this size at this byte offset (little-endian).
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         SZ_BYTE: m = 4'b0001 << addr;
         SZ_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Right-justified store data copied into every lane it could occupy.
   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {4{data[7:0]}};
         SZ_HALF: r = {2{data[15:0]}};
         default: r = data;
      endcase
      return r;
   endfunction

   // Natural alignment check; the reserved size encoding is never legal.
   function automatic logic aligned(input logic [1:0] size, input logic [1:0] addr);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~addr[0];
         SZ_WORD: ok = (addr == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Inserts a byte/halfword/word into its little-endian lanes of an old word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module byte_lane_merge
   import store_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  addr,
   output logic [31:0] merged
);

   logic [3:0]  mask;
   logic [31:0] rep;

   // Per lane, take the replicated store byte where the mask selects it, else keep the old byte.
   always_comb begin
      mask   = lane_mask(size, addr);
      rep    = replicate(size, data);
      merged = old_word;
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) merged[8*k +: 8] = rep[8*k +: 8];
      end
   end

endmodule

// File: rtl/store_byte_merge.sv
// SB/SH/SW into word memory: read-modify-write for narrow stores, direct write for words.
// Latency: SW write at +1, done at +2; SB/SH write one cycle after read valid, done one after.
// Backpressure: Busy stalls the pipeline; read latency unbounded. Option macro STORE_BYTE_ENABLE_EN adds MemByteEn.
module store_byte_merge
   import store_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 30
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WrData,
   input  logic [1:0]        Size,
   output logic              Busy,
   output logic              Done,
   output logic              AlignErr,
   output logic [MEM_AW-1:0] MemAddr,
   output logic              MemRdEn,
   input  logic [31:0]       MemRdData,
   input  logic              MemRdValid,
   output logic              MemWrEn,
   output logic [31:0]       MemWrData
`ifdef STORE_BYTE_ENABLE_EN
   ,
   output logic [3:0]        MemByteEn
`endif
);

   state_e state, state_nxt;
   logic   legal;
   logic   accept;
   logic   reject;

   assign legal = aligned(Size, Addr[1:0]);

   // State register; reset mid-store drops the operation before any write.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next state and state-decoded strobes; Start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      Busy      = (state != S_IDLE);
      MemRdEn   = (state == S_RD_REQ);
      MemWrEn   = (state == S_WRITE);
      Done      = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (Start) begin
               if (legal) begin
                  accept = 1'b1;
`ifdef STORE_BYTE_ENABLE_EN
                  state_nxt = S_WRITE;
`else
                  state_nxt = (Size == SZ_WORD) ? S_WRITE : S_RD_REQ;
`endif
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_RD_REQ:  state_nxt = S_RD_WAIT;
         S_RD_WAIT: if (MemRdValid) state_nxt = S_WRITE;
         S_WRITE:   state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

`ifdef STORE_BYTE_ENABLE_EN
   // Byte-enable memory: everything is known at accept time, no read needed.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         AlignErr  <= 1'b0;
         MemAddr   <= '0;
         MemWrData <= '0;
         MemByteEn <= '0;
      end else begin
         AlignErr <= reject;
         if (accept) begin
            MemAddr   <= Addr[ADDR_W-1:2];
            MemWrData <= replicate(Size, WrData);
            MemByteEn <= lane_mask(Size, Addr[1:0]);
         end
      end
   end
`else
   logic [31:0] cap_data;
   logic [1:0]  cap_size;
   logic [1:0]  cap_lane;
   logic [31:0] merged;

   byte_lane_merge u_merge (
      .old_word (MemRdData),
      .data     (cap_data),
      .size     (cap_size),
      .addr     (cap_lane),
      .merged   (merged)
   );

   // Capture the request at accept; the merged word lands when the read returns.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         AlignErr  <= 1'b0;
         MemAddr   <= '0;
         MemWrData <= '0;
         cap_data  <= '0;
         cap_size  <= '0;
         cap_lane  <= '0;
      end else begin
         AlignErr <= reject;
         if (accept) begin
            MemAddr   <= Addr[ADDR_W-1:2];
            MemWrData <= WrData;
            cap_data  <= WrData;
            cap_size  <= Size;
            cap_lane  <= Addr[1:0];
         end
         if (state == S_RD_WAIT && MemRdValid) MemWrData <= merged;
      end
   end
`endif

endmodule

// File: tb/tb_store_byte_merge.sv
// Bench for store_byte_merge: vector table, corner sequences, random stores vs a byte-array model.
// Latency: checks exact strobe cycles relative to Start.
// Backpressure: models variable read latency with stray valids outside the wait state.
module tb_store_byte_merge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [1:0]  size;
   logic        busy, done, align_err;
   logic [29:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
   logic        mem_rd_valid;
   logic        mem_wr_en;
   logic [31:0] mem_wr_data;
`ifdef STORE_BYTE_ENABLE_EN
   logic [3:0]  mem_byte_en;
`endif

   logic [31:0] l_old, l_data, l_merged;
   logic [1:0]  l_size, l_addr;

   always #5 clk = ~clk;

   store_byte_merge #(.ADDR_W(32), .MEM_AW(30)) dut (
      .Clk        (clk),
      .Reset_n    (rst_n),
      .Start      (start),
      .Addr       (addr),
      .WrData     (wr_data),
      .Size       (size),
      .Busy       (busy),
      .Done       (done),
      .AlignErr   (align_err),
      .MemAddr    (mem_addr),
      .MemRdEn    (mem_rd_en),
      .MemRdData  (mem_rd_data),
      .MemRdValid (mem_rd_valid),
      .MemWrEn    (mem_wr_en),
      .MemWrData  (mem_wr_data)
`ifdef STORE_BYTE_ENABLE_EN
      ,
      .MemByteEn  (mem_byte_en)
`endif
   );

   byte_lane_merge u_lane (
      .old_word (l_old),
      .data     (l_data),
      .size     (l_size),
      .addr     (l_addr),
      .merged   (l_merged)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model: memory word as four bytes ----------------
   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit model_legal(input logic [1:0] sz, input logic [1:0] a);
      if (sz == 2'b11) return 1'b0;
      return (int'(a) % nbytes(sz)) == 0;
   endfunction

   function automatic logic [31:0] model_rmw(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] a);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      for (int i = 0; i < nbytes(sz); i++) b[int'(a) + i] = d[8*i +: 8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic logic [31:0] model_rep(input logic [31:0] d, input logic [1:0] sz);
      logic [7:0] b [4];
      for (int k = 0; k < 4; k++) b[k] = d[8*(k % nbytes(sz)) +: 8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 0; i < nbytes(sz); i++) m[int'(a) + i] = 1'b1;
      return m;
   endfunction

   // ---------------- transaction driver / observer ----------------
   typedef struct {
      int          nrd, nwr, ndone, nerr;
      int          rd_cyc, wr_cyc, done_cyc, err_cyc;
      int          busy_cnt, idle_early;
      logic        busy_last;
      logic [29:0] raddr, waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } res_t;

   // Called at a negedge; Start is driven during cycle 0, sampling on later negedges.
   task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input logic [31:0] mem, input int delay, input bit spur,
                            input bit busy_start, output res_t r);
      int valid_cyc;
      valid_cyc = -1;
      r.nrd = 0; r.nwr = 0; r.ndone = 0; r.nerr = 0;
      r.rd_cyc = -1; r.wr_cyc = -1; r.done_cyc = -1; r.err_cyc = -1;
      r.busy_cnt = 0; r.idle_early = 0; r.busy_last = 1'b1;
      r.raddr = '0; r.waddr = '0; r.wdata = '0; r.be = '0;
      start = 1'b1; addr = a; size = sz; wr_data = d;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         mem_rd_valid = 1'b0;
         mem_rd_data = $urandom;
         if (busy_start && cyc == 2) begin
            start = 1'b1; addr = a ^ 32'h0000_1004; wr_data = ~d; size = 2'b00;
         end
         if (busy) r.busy_cnt++;
         if (!busy && r.nwr == 0 && r.nerr == 0) r.idle_early++;
         r.busy_last = busy;
         if (mem_rd_en) begin
            r.nrd++; r.rd_cyc = cyc; r.raddr = mem_addr; valid_cyc = cyc + 1 + delay;
         end
         if (mem_wr_en) begin
            r.nwr++; r.wr_cyc = cyc; r.waddr = mem_addr; r.wdata = mem_wr_data;
`ifdef STORE_BYTE_ENABLE_EN
            r.be = mem_byte_en;
`endif
         end
         if (done)      begin r.ndone++; r.done_cyc = cyc; end
         if (align_err) begin r.nerr++;  r.err_cyc = cyc;  end
         if (cyc == valid_cyc) begin
            mem_rd_valid = 1'b1; mem_rd_data = mem;
         end else if (spur && cyc == 1) begin
            mem_rd_valid = 1'b1; mem_rd_data = ~mem;
         end
         if ((r.ndone > 0 && cyc > r.done_cyc) || (r.nerr > 0 && cyc >= 3)) break;
      end
      start = 1'b0;
      mem_rd_valid = 1'b0;
   endtask

   task automatic check_txn(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input int delay, input res_t r, input bit exp_err,
                            input logic [31:0] exp_wd, input logic [3:0] exp_be);
      bit narrow;
`ifdef STORE_BYTE_ENABLE_EN
      narrow = 1'b0;
`else
      narrow = (sz != 2'b10);
`endif
      if (exp_err) begin
         check({tag, "/err_cnt"},  32'(r.nerr), 32'd1);
         check({tag, "/err_cyc"},  32'(r.err_cyc), 32'd1);
         check({tag, "/rd_cnt"},   32'(r.nrd), 32'd0);
         check({tag, "/wr_cnt"},   32'(r.nwr), 32'd0);
         check({tag, "/done_cnt"}, 32'(r.ndone), 32'd0);
         check({tag, "/busy_cnt"}, 32'(r.busy_cnt), 32'd0);
      end else begin
         check({tag, "/err_cnt"}, 32'(r.nerr), 32'd0);
         check({tag, "/rd_cnt"},  32'(r.nrd), narrow ? 32'd1 : 32'd0);
         if (narrow) begin
            check({tag, "/rd_cyc"},  32'(r.rd_cyc), 32'd1);
            check({tag, "/rd_addr"}, 32'(r.raddr), 32'(a[31:2]));
         end
         check({tag, "/wr_cnt"},   32'(r.nwr), 32'd1);
         check({tag, "/wr_cyc"},   32'(r.wr_cyc), narrow ? 32'(3 + delay) : 32'd1);
         check({tag, "/wr_addr"},  32'(r.waddr), 32'(a[31:2]));
         check({tag, "/wr_data"},  r.wdata, exp_wd);
         check({tag, "/done_cnt"}, 32'(r.ndone), 32'd1);
         check({tag, "/done_cyc"}, 32'(r.done_cyc), narrow ? 32'(4 + delay) : 32'd2);
         check({tag, "/busy_gap"}, 32'(r.idle_early), 32'd0);
         check({tag, "/busy_end"}, 32'(r.busy_last), 32'd0);
`ifdef STORE_BYTE_ENABLE_EN
         check({tag, "/byte_en"}, 32'(r.be), 32'(exp_be));
`else
         if (exp_be == 4'hF && r.be != 4'h0) check({tag, "/be_unused"}, 32'(r.be), 32'd0);
`endif
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] addr;
      logic [1:0]  sz;
      logic [31:0] data;
      logic [31:0] mem;
      int          delay;
      bit          err;
      logic [31:0] wd_rmw;
      logic [31:0] wd_be;
      logic [3:0]  be;
   } vec_t;

   vec_t vt [11];

   initial begin
      res_t        r;
      logic [31:0] a, d, m, wd;
      logic [1:0]  sz;
      int          dly;
      bit          legal;
      int          wr_seen;

      vt[0]  = '{32'h102, 2'b00, 32'h0000_00AB, 32'h1122_3344, 0, 1'b0, 32'h11AB_3344, 32'hABAB_ABAB, 4'b0100};
      vt[1]  = '{32'h202, 2'b01, 32'h0000_1234, 32'hDEAD_BEEF, 4, 1'b0, 32'h1234_BEEF, 32'h1234_1234, 4'b1100};
      vt[2]  = '{32'h300, 2'b10, 32'hCAFE_F00D, 32'h0000_0000, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111};
      vt[3]  = '{32'h101, 2'b01, 32'h0000_1234, 32'h0000_0000, 0, 1'b1, 32'h0,         32'h0,         4'b0000};
      vt[4]  = '{32'h102, 2'b10, 32'h1234_5678, 32'h0000_0000, 0, 1'b1, 32'h0,         32'h0,         4'b0000};
      vt[5]  = '{32'h100, 2'b11, 32'h1234_5678, 32'h0000_0000, 0, 1'b1, 32'h0,         32'h0,         4'b0000};
      vt[6]  = '{32'h103, 2'b00, 32'hFFFF_FF5A, 32'h0000_0000, 1, 1'b0, 32'h5A00_0000, 32'h5A5A_5A5A, 4'b1000};
      vt[7]  = '{32'h100, 2'b00, 32'h0000_0077, 32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FF77, 32'h7777_7777, 4'b0001};
      vt[8]  = '{32'h200, 2'b01, 32'hABCD_5555, 32'h1122_3344, 2, 1'b0, 32'h1122_5555, 32'h5555_5555, 4'b0011};
      vt[9]  = '{32'h101, 2'b00, 32'h0000_00C3, 32'h1122_3344, 0, 1'b0, 32'h1122_C344, 32'hC3C3_C3C3, 4'b0010};
      vt[10] = '{32'h202, 2'b01, 32'h0000_FFFF, 32'h0000_0000, 0, 1'b0, 32'hFFFF_0000, 32'hFFFF_FFFF, 4'b1100};

      rst_n = 1'b0; start = 1'b0; addr = '0; wr_data = '0; size = '0;
      mem_rd_data = '0; mem_rd_valid = 1'b0;
      l_old = '0; l_data = '0; l_size = '0; l_addr = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst/busy",     32'(busy), 32'd0);
      check("rst/done",     32'(done), 32'd0);
      check("rst/alignerr", 32'(align_err), 32'd0);
      check("rst/rd_en",    32'(mem_rd_en), 32'd0);
      check("rst/wr_en",    32'(mem_wr_en), 32'd0);
      check("rst/mem_addr", 32'(mem_addr), 32'd0);
      check("rst/wr_data",  mem_wr_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table, back-to-back
      for (int i = 0; i < 11; i++) begin
         run_store(vt[i].addr, vt[i].sz, vt[i].data, vt[i].mem, vt[i].delay, 1'b0, 1'b0, r);
`ifdef STORE_BYTE_ENABLE_EN
         wd = vt[i].wd_be;
`else
         wd = vt[i].wd_rmw;
`endif
         check_txn($sformatf("vec%0d", i), vt[i].addr, vt[i].sz, vt[i].delay, r, vt[i].err, wd, vt[i].be);
      end

      // Start pulsed while busy must not launch a second store
      run_store(32'h206, 2'b01, 32'h0000_BEEF, 32'h0102_0304, 2, 1'b0, 1'b1, r);
`ifdef STORE_BYTE_ENABLE_EN
      wd = model_rep(32'h0000_BEEF, 2'b01);
`else
      wd = model_rmw(32'h0102_0304, 32'h0000_BEEF, 2'b01, 2'b10);
`endif
      check_txn("busy_start", 32'h206, 2'b01, 2, r, 1'b0, wd, model_be(2'b01, 2'b10));
      repeat (3) begin
         @(negedge clk);
         check("busy_start/quiet", 32'(busy | done | mem_wr_en | mem_rd_en), 32'd0);
      end

      // Reset while the store is in flight aborts it
      start = 1'b1; addr = 32'h400; size = 2'b00; wr_data = 32'h99;
      @(negedge clk);
      start = 1'b0;
`ifndef STORE_BYTE_ENABLE_EN
      @(negedge clk);
`endif
      check("abort/busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort/busy",     32'(busy), 32'd0);
      check("abort/done",     32'(done), 32'd0);
      check("abort/alignerr", 32'(align_err), 32'd0);
      check("abort/rd_en",    32'(mem_rd_en), 32'd0);
      check("abort/wr_en",    32'(mem_wr_en), 32'd0);
      check("abort/mem_addr", 32'(mem_addr), 32'd0);
      check("abort/wr_data",  mem_wr_data, 32'd0);
      mem_rd_valid = 1'b1; mem_rd_data = 32'h5555_5555;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_wr_en || done || busy) wr_seen++;
      end
      check("abort/no_write", 32'(wr_seen), 32'd0);
      mem_rd_valid = 1'b0;

      // Lane-merge sub-block, random legal combinations
      for (int i = 0; i < 40; i++) begin
         l_size = 2'($urandom_range(0, 2));
         l_addr = 2'($urandom_range(0, 3));
         if (l_size == 2'b01) l_addr[0] = 1'b0;
         if (l_size == 2'b10) l_addr = 2'b00;
         l_old = $urandom; l_data = $urandom;
         #1;
         check($sformatf("lane%0d", i), l_merged, model_rmw(l_old, l_data, l_size, l_addr));
      end
      @(negedge clk);

      // Random stores against the byte-array model
      for (int i = 0; i < 250; i++) begin
         sz = 2'($urandom_range(0, 3));
         a = $urandom; d = $urandom; m = $urandom;
         dly = $urandom_range(0, 3);
         legal = model_legal(sz, a[1:0]);
         run_store(a, sz, d, m, dly, 1'($urandom_range(0, 1)), 1'b0, r);
`ifdef STORE_BYTE_ENABLE_EN
         wd = legal ? model_rep(d, sz) : 32'h0;
`else
         wd = legal ? model_rmw(m, d, sz, a[1:0]) : 32'h0;
`endif
         check_txn($sformatf("rnd%0d", i), a, sz, dly, r, !legal, wd,
                   legal ? model_be(sz, a[1:0]) : 4'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_byte_merge.md
Name: store_byte_merge

Overview:
- Store-side counterpart of the load-path byte/halfword sign extension: implements SB/SH/SW into the word-wide data memory.
- Narrow stores run a read-modify-write sequence: read the word, insert the byte/halfword into its lane, write the word back.
- Word stores bypass the read.
- Sits between the MEM-stage store request and the data memory port; the pipeline stalls on Busy.

Parameters:
- ADDR_W, 32, byte-address width of Addr.
- MEM_AW, 30, word-address width of MemAddr (= ADDR_W-2).

Ports:
- Clk  input  1  clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  store request; sampled only in IDLE.
- Addr  input  ADDR_W  byte address of the store.
- WrData  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle completion pulse.
- AlignErr  output  1  one-cycle pulse; request rejected, no memory access.
- MemAddr  output  MEM_AW  word address = captured Addr[ADDR_W-1:2].
- MemRdEn  output  1  one-cycle read request.
- MemRdData  input  32  read word.
- MemRdValid  input  1  read data valid; earliest the cycle after MemRdEn, unbounded latency.
- MemWrEn  output  1  one-cycle write strobe.
- MemWrData  output  32  merged write word.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE. Busy, Done, AlignErr, MemRdEn and MemWrEn are 0. MemAddr, MemWrData and the capture registers are 0. Reset mid-operation aborts the store; no write is issued.
- Lane mapping is little-endian. Byte lane k = Addr[1:0] occupies bits [8k+7:8k]. A halfword at Addr[1]=h occupies [16h+15:16h].
- Alignment rules:
  - SH requires Addr[0]=0.
  - SW requires Addr[1:0]=00.
  - Size=11 is always illegal.
- FSM states: IDLE, RD_REQ, RD_WAIT, WRITE, DONE.
  - IDLE, Start=1, illegal or misaligned: AlignErr=1 next cycle; stay in IDLE; no Busy.
  - IDLE, Start=1, SW: capture inputs, go to WRITE (MemWrData=WrData).
  - IDLE, Start=1, SB/SH: capture Addr, WrData and Size; go to RD_REQ.
  - RD_REQ: MemRdEn=1 for exactly one cycle, then go to RD_WAIT.
  - RD_WAIT: hold until MemRdValid=1. Then MemWrData = MemRdData with the target lane replaced by captured data. Go to WRITE.
  - WRITE: MemWrEn=1 for exactly one cycle, then go to DONE.
  - DONE: Done=1 for one cycle, then go to IDLE. Start may be accepted on the first IDLE cycle.
- Latency, Start at cycle 0:
  - SB/SH with 1-cycle read: MemRdEn at 1, MemRdValid at 2, MemWrEn at 3, Done at 4.
  - SW: MemWrEn at 1, Done at 2.
- Start while Busy: ignored. Inputs are not re-sampled.
- MemRdValid outside RD_WAIT: ignored.
- MemAddr is held stable from RD_REQ through WRITE.
- Unused WrData bits above the store size are ignored.

Optional Feature:
- Macro: STORE_BYTE_ENABLE_EN.
- Defined:
  - Adds output port MemByteEn[3:0].
  - All legal sizes go IDLE -> WRITE -> DONE; MemRdEn is never asserted.
  - MemWrData holds the store data replicated into every lane.
  - MemByteEn is one-hot on the byte lane, 0011/1100 for halfwords, 1111 for SW.
- Undefined: read-modify-write as above; no MemByteEn port.

Decomposition:
- Package store_pkg:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encodings: S_IDLE, S_RD_REQ, S_RD_WAIT, S_WRITE, S_DONE.
  - Function lane_mask(size, addr[1:0]) returning the 4-bit lane mask.
- Sub-module byte_lane_merge: combinational function (old_word, data, size, addr[1:0]) -> merged word. It is unit-tested separately.
- The FSM stays in the top module.

Test Plan:
- SB: memory word 0x11223344, Addr=0x102, WrData=0x000000AB -> one read of MemAddr=0x40, then MemWrData=0x11AB3344, Done 4 cycles after Start.
- SH: memory 0xDEADBEEF, Addr=0x202, WrData=0x00001234 -> MemWrData=0x1234BEEF. MemRdValid delayed 5 cycles: Busy held, MemWrEn one cycle after valid.
- SW: Addr=0x300, WrData=0xCAFEF00D -> no MemRdEn, MemWrEn at cycle 1, MemWrData=0xCAFEF00D, Done at 2.
- Misaligned/illegal requests each give one AlignErr pulse with no MemRdEn/MemWrEn: SH Addr=0x101, SW Addr=0x102, Size=11.
- Reset: Reset_n low during RD_WAIT -> all outputs 0 immediately, no MemWrEn. Start pulsed while Busy -> ignored, single Done.
- STORE_BYTE_ENABLE_EN: SB Addr=0x103, WrData=0x5A -> MemByteEn=1000, MemWrData=0x5A5A5A5A, no read, Done at 2.
